// File: rtl/m3_key_cmd_decode.sv
// Operator key front-end for m3_powerAndSpeedCalc: sync, debounce and decode of seven raw keys.
// Optional INC/DEC auto-repeat is built when M3_KEY_AUTOREPEAT_EN is defined.
module m3_key_cmd_decode #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_DELAY    = 500000,
    parameter int unsigned REPEAT_PERIOD   = 100000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clkI,
    input  logic nRstI,
    input  logic keyStartI,
    input  logic keyStopI,
    input  logic keyInvI,
    input  logic keySpdIncI,
    input  logic keySpdDecI,
    input  logic keyPwrIncI,
    input  logic keyPwrDecI,
    output logic m3startO,
    output logic m3forceStopO,
    output logic m3invRotateO,
    output logic m3speedINCo,
    output logic m3speedDECo,
    output logic m3powerINCo,
    output logic m3powerDECo
);

    localparam int K_START   = 0;
    localparam int K_STOP    = 1;
    localparam int K_INV     = 2;
    localparam int K_SPD_INC = 3;
    localparam int K_SPD_DEC = 4;
    localparam int K_PWR_INC = 5;
    localparam int K_PWR_DEC = 6;
    localparam int NKEYS     = 7;

    localparam logic [14:0] DB_LAST = 15'(DEBOUNCE_CYCLES - 1);

    logic [NKEYS-1:0]       w_key_raw;
    logic [NKEYS-1:0]       w_key_norm;
    logic [NKEYS-1:0]       r_sync1;
    logic [NKEYS-1:0]       r_sync2;
    logic [NKEYS-1:0]       r_sync_prev;
    logic [NKEYS-1:0]       r_deb;
    logic [NKEYS-1:0]       r_deb_prev;
    logic [NKEYS-1:0][14:0] r_db_cnt;
    logic [NKEYS-1:0]       w_rise;
    logic [3:0]             w_rpt_fire;
    logic                   w_stop_held;
    logic                   w_spd_conf;
    logic                   w_pwr_conf;

    logic r_start;
    logic r_fstop;
    logic r_inv;
    logic r_spd_inc;
    logic r_spd_dec;
    logic r_pwr_inc;
    logic r_pwr_dec;

    assign w_key_raw = {keyPwrDecI, keyPwrIncI, keySpdDecI, keySpdIncI,
                        keyInvI, keyStopI, keyStartI};

    // Normalising ahead of the synchroniser lets every flop reset to 0 = released.
    assign w_key_norm = KEY_ACTIVE_LOW ? ~w_key_raw : w_key_raw;

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_sync_prev <= '0;
            r_deb       <= '0;
            r_deb_prev  <= '0;
            r_db_cnt    <= '0;
        end else begin
            r_sync1     <= w_key_norm;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_deb_prev  <= r_deb;
            for (int k = 0; k < NKEYS; k++) begin
                if ((r_sync2[k] == r_deb[k]) || (r_sync2[k] != r_sync_prev[k])) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_deb[k]    <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 15'd1;
                end
            end
        end
    end

    assign w_rise      = r_deb & ~r_deb_prev;
    assign w_stop_held = r_deb[K_STOP];
    assign w_spd_conf  = r_deb[K_SPD_INC] & r_deb[K_SPD_DEC];
    assign w_pwr_conf  = r_deb[K_PWR_INC] & r_deb[K_PWR_DEC];

`ifdef M3_KEY_AUTOREPEAT_EN
    localparam logic [19:0] RPT_DELAY_LAST  = 20'(REPEAT_DELAY - 1);
    localparam logic [19:0] RPT_PERIOD_LAST = 20'(REPEAT_PERIOD - 1);

    logic [3:0]       r_rpt_act;
    logic [3:0][19:0] r_rpt_cnt;

    // Down-counters: loaded on the press event, fire at zero, reload with the period.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_rpt_act <= '0;
            r_rpt_cnt <= '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (!r_deb[K_SPD_INC + j]) begin
                    r_rpt_act[j] <= 1'b0;
                    r_rpt_cnt[j] <= '0;
                end else if (w_rise[K_SPD_INC + j]) begin
                    r_rpt_act[j] <= 1'b1;
                    r_rpt_cnt[j] <= RPT_DELAY_LAST;
                end else if (r_rpt_act[j]) begin
                    if (r_rpt_cnt[j] == '0) begin
                        r_rpt_cnt[j] <= RPT_PERIOD_LAST;
                    end else begin
                        r_rpt_cnt[j] <= r_rpt_cnt[j] - 20'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rpt_fire = '0;
        for (int j = 0; j < 4; j++) begin
            w_rpt_fire[j] = r_rpt_act[j] & r_deb[K_SPD_INC + j] & ~w_rise[K_SPD_INC + j] &
                            (r_rpt_cnt[j] == '0);
        end
    end
`else
    assign w_rpt_fire = '0;
`endif

    // Each pulse is gated by its own previous value so no output is high two cycles running.
    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            r_start   <= 1'b0;
            r_fstop   <= 1'b0;
            r_inv     <= 1'b0;
            r_spd_inc <= 1'b0;
            r_spd_dec <= 1'b0;
            r_pwr_inc <= 1'b0;
            r_pwr_dec <= 1'b0;
        end else begin
            r_start   <= w_rise[K_START] & ~w_stop_held & ~r_start;
            r_fstop   <= w_rise[K_STOP] & ~r_fstop;
            if (w_rise[K_INV] && !w_stop_held) begin
                r_inv <= ~r_inv;
            end
            r_spd_inc <= (w_rise[K_SPD_INC] | w_rpt_fire[0]) & ~w_stop_held & ~w_spd_conf &
                         ~r_spd_inc;
            r_spd_dec <= (w_rise[K_SPD_DEC] | w_rpt_fire[1]) & ~w_stop_held & ~w_spd_conf &
                         ~r_spd_dec;
            r_pwr_inc <= (w_rise[K_PWR_INC] | w_rpt_fire[2]) & ~w_stop_held & ~w_pwr_conf &
                         ~r_pwr_inc;
            r_pwr_dec <= (w_rise[K_PWR_DEC] | w_rpt_fire[3]) & ~w_stop_held & ~w_pwr_conf &
                         ~r_pwr_dec;
        end
    end

    assign m3startO     = r_start;
    assign m3forceStopO = r_fstop;
    assign m3invRotateO = r_inv;
    assign m3speedINCo  = r_spd_inc;
    assign m3speedDECo  = r_spd_dec;
    assign m3powerINCo  = r_pwr_inc;
    assign m3powerDECo  = r_pwr_dec;

endmodule

// File: tb/tb_m3_key_cmd_decode.sv
// Bench for m3_key_cmd_decode: vector table, corner sequences and random keys vs a window model.
`timescale 1ns/1ps
module tb_m3_key_cmd_decode;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef M3_KEY_AUTOREPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] p;      // 1 = key pressed; index order start,stop,inv,si,sd,pi,pd
    wire  [6:0] o;

    always #5 clk = ~clk;

    m3_key_cmd_decode #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clkI(clk),
        .nRstI(rst_n),
        .keyStartI(~p[0]),
        .keyStopI(~p[1]),
        .keyInvI(~p[2]),
        .keySpdIncI(~p[3]),
        .keySpdDecI(~p[4]),
        .keyPwrIncI(~p[5]),
        .keyPwrDecI(~p[6]),
        .m3startO(o[0]),
        .m3forceStopO(o[1]),
        .m3invRotateO(o[2]),
        .m3speedINCo(o[3]),
        .m3speedDECo(o[4]),
        .m3powerINCo(o[5]),
        .m3powerDECo(o[6])
    );

    int n_vec = 0;
    int n_err = 0;
    int rel   = 0;
    int pcnt[7];
    int pfirst[7];
    int plast[7];

    // Reference model: a key is accepted once the last D+1 synced samples agree on a new value.
    bit hist[7][$];
    bit deb[7];
    bit debp[7];
    int age[7];
    bit exp_o[7];

    task automatic model_reset();
        for (int k = 0; k < 7; k++) begin
            hist[k].delete();
            repeat (D + 3) hist[k].push_back(1'b0);
            deb[k]   = 1'b0;
            debp[k]  = 1'b0;
            age[k]   = 0;
            exp_o[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit rise[7];
        bit nxt[7];
        bit stop;
        bit fire;
        bit pair;
        bit all_v;
        stop = deb[1];
        for (int k = 0; k < 7; k++) rise[k] = deb[k] && !debp[k];
        nxt[0] = rise[0] && !stop && !exp_o[0];
        nxt[1] = rise[1] && !exp_o[1];
        nxt[2] = exp_o[2] ^ (rise[2] && !stop);
        for (int k = 3; k < 7; k++) begin
            fire = 1'b0;
            if (rise[k]) begin
                age[k] = 0;
            end else if (deb[k]) begin
                age[k]++;
                fire = RPT && (age[k] >= RD) && (((age[k] - RD) % RP) == 0);
            end
            pair = (k < 5) ? (deb[3] && deb[4]) : (deb[5] && deb[6]);
            nxt[k] = (rise[k] || fire) && !stop && !pair && !exp_o[k];
        end
        for (int k = 0; k < 7; k++) exp_o[k] = nxt[k];
        for (int k = 0; k < 7; k++) begin
            debp[k] = deb[k];
            all_v = 1'b1;
            for (int j = 1; j <= D + 1; j++) begin
                if (hist[k][j] == deb[k]) all_v = 1'b0;
            end
            if (all_v) deb[k] = !deb[k];
            hist[k].push_front(p[k]);
            void'(hist[k].pop_back());
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic check_cycle(input int e);
        logic [6:0] want;
        for (int k = 0; k < 7; k++) want[k] = exp_o[k];
        n_vec++;
        if (o !== want) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL outputs at t=%0t rel edge %0d: got %b, want %b", $time, e, o, want);
        end
        for (int k = 0; k < 7; k++) begin
            if (k != 2 && o[k] === 1'b1) begin
                pcnt[k]++;
                if (pfirst[k] < 0) pfirst[k] = e;
                plast[k] = e;
            end
        end
    endtask

    task automatic step();
        int e;
        @(posedge clk);
        e = rel;
        rel++;
        if (rst_n) model_edge();
        @(negedge clk);
        check_cycle(e);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_rec();
        rel = 0;
        for (int k = 0; k < 7; k++) begin
            pcnt[k]   = 0;
            pfirst[k] = -1;
            plast[k]  = -1;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        run(n);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int key;
        int hold;
        int first;
        int cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0, 40, 7, 1};
        tbl[1] = '{1, 40, 7, 1};
        tbl[2] = '{3, 60, 7, RPT ? 6 : 1};
        tbl[3] = '{4, 30, 7, RPT ? 3 : 1};
        tbl[4] = '{5, 10, 7, 1};
        tbl[5] = '{6, 28, 7, RPT ? 2 : 1};
        tbl[6] = '{3, 3, -1, 0};
        tbl[7] = '{5, 4, -1, 0};
        tbl[8] = '{6, 5, 7, 1};

        p = '0;
        clear_rec();
        do_reset(3);
        check_val("reset_outputs", int'(o), 0);

        // Single-key presses: latency, debounce boundary and repeat counts.
        for (int i = 0; i < 9; i++) begin
            do_reset(2);
            run(5);
            clear_rec();
            p[tbl[i].key] = 1'b1;
            run(tbl[i].hold);
            p[tbl[i].key] = 1'b0;
            run(40);
            check_val($sformatf("tbl%0d_first", i), pfirst[tbl[i].key], tbl[i].first);
            check_val($sformatf("tbl%0d_count", i), pcnt[tbl[i].key], tbl[i].cnt);
        end

        // Glitch train on speed-inc, then a long hold.
        do_reset(2);
        run(5);
        clear_rec();
        for (int i = 0; i < 5; i++) begin
            p[3] = 1'b1;
            run(3);
            p[3] = 1'b0;
            run(3);
        end
        run(10);
        check_val("glitch_count", pcnt[3], 0);
        clear_rec();
        p[3] = 1'b1;
        run(60);
        p[3] = 1'b0;
        run(40);
        check_val("hold_first", pfirst[3], 7);
        check_val("hold_count", pcnt[3], RPT ? 6 : 1);
        check_val("hold_last", plast[3], RPT ? 59 : 7);

        // Stop held suppresses start and power pulses.
        do_reset(2);
        run(5);
        clear_rec();
        p[1] = 1'b1;
        run(10);
        p[0] = 1'b1;
        p[5] = 1'b1;
        run(20);
        p = '0;
        run(30);
        check_val("stophold_fstop", pcnt[1], 1);
        check_val("stophold_start", pcnt[0], 0);
        check_val("stophold_pwrinc", pcnt[5], 0);

        // Start and stop on the same edge.
        do_reset(2);
        run(5);
        clear_rec();
        p[0] = 1'b1;
        p[1] = 1'b1;
        run(20);
        p = '0;
        run(20);
        check_val("simul_fstop", pcnt[1], 1);
        check_val("simul_fstop_first", pfirst[1], 7);
        check_val("simul_start", pcnt[0], 0);

        // Direction toggling, then a toggle attempt while stop is held.
        do_reset(2);
        run(5);
        for (int i = 0; i < 3; i++) begin
            p[2] = 1'b1;
            run(10);
            p[2] = 1'b0;
            run(10);
            check_val($sformatf("inv_press%0d", i), int'(o[2]), (i % 2 == 0) ? 1 : 0);
        end
        p[1] = 1'b1;
        run(10);
        p[2] = 1'b1;
        run(10);
        p[2] = 1'b0;
        run(10);
        p[1] = 1'b0;
        run(10);
        check_val("inv_blocked", int'(o[2]), 1);

        // Power conflict, reset mid-hold, then single key left held.
        do_reset(2);
        run(5);
        clear_rec();
        p[5] = 1'b1;
        p[6] = 1'b1;
        run(30);
        check_val("conf_pwrinc", pcnt[5], 0);
        check_val("conf_pwrdec", pcnt[6], 0);
        rst_n = 1'b0;
        model_reset();
        step();
        check_val("midreset_outputs", int'(o), 0);
        p[6] = 1'b0;
        step();
        check_val("midreset_outputs2", int'(o), 0);
        rst_n = 1'b1;
        clear_rec();
        run(20);
        check_val("postrst_pwrinc_first", pfirst[5], D + 3);
        check_val("postrst_pwrinc_count", pcnt[5], 1);
        check_val("postrst_pwrdec_count", pcnt[6], 0);
        p = '0;
        run(20);

        // Random key activity with occasional resets, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            int dv;
            dv = (c < 1500) ? 6 : 40;
            for (int k = 0; k < 7; k++) begin
                if ($urandom_range(dv - 1) == 0) p[k] = ~p[k];
            end
            if ($urandom_range(499) == 0) do_reset(2);
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
